t_ff_bank_ctrl: RTL and testbench

Command-driven sequencer for a bank of W T flip-flops, one existing t_ff cell per bit.
- Accepts one command at a time over a valid/ready handshake.
- Derives the per-bit T vector each cycle to toggle, set, clear or pulse-toggle the selected bits.
- Reports completion with a one-cycle done strobe.
- Sits between a register/config front end and the T-FF storage; the bank q is exported as status.

---
 rtl/t_ff_pkg.sv | 17 +
 rtl/t_ff_bank_ctrl_if.sv | 24 ++
 rtl/t_ff_bank_ctrl_t_ff.sv | 19 +
 rtl/t_ff_bank_ctrl.sv | 105 ++++++++++
 tb/tb_t_ff_bank_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/t_ff_pkg.sv
// Shared op encodings and controller state type for the T-FF bank sequencer.
package t_ff_pkg;

    typedef enum logic [1:0] {
        OP_TOGGLE = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_PULSE  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/t_ff_bank_ctrl_if.sv
// Command channel into the T-FF bank controller: valid/ready handshake plus abort.
interface t_ff_bank_ctrl_if
    import t_ff_pkg::*;
#(
    parameter int W    = 8,
    parameter int CNTW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    op_e             cmd_op;
    logic [W-1:0]    cmd_mask;
    logic [CNTW-1:0] cmd_count;
    logic            abort;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_count, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_count, abort,
        output cmd_ready
    );
endinterface

// File: rtl/t_ff_bank_ctrl_t_ff.sv
// Single T flip-flop storage cell with asynchronous active-low reset.
module t_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);
    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/t_ff_bank_ctrl.sv
// Command sequencer driving a bank of W T flip-flops: toggle/clear/set/pulse selected bits.
// One command in flight; done/aborted strobe one cycle after the last EXEC edge.
module t_ff_bank_ctrl
    import t_ff_pkg::*;
#(
    parameter int W    = 8,
    parameter int CNTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    t_ff_bank_ctrl_if.slave cmd,
    output logic [W-1:0]   t_vec,
    output logic [W-1:0]   q,
    output logic           busy,
    output logic           done,
    output logic           aborted
);
    state_e          state_q, state_d;
    op_e             op_q;
    logic [W-1:0]    mask_q;
    logic [CNTW-1:0] cnt_q;
    logic            ready_q, busy_q, done_q, aborted_q;
    logic            aborted_d;
    logic [W-1:0]    t_raw;
    logic            rst_n;

    always_comb begin
        t_raw = '0;
        case (op_q)
            OP_TOGGLE: t_raw = mask_q;
            OP_CLEAR:  t_raw = q & mask_q;
            OP_SET:    t_raw = ~q & mask_q;
            OP_PULSE:  t_raw = mask_q;
            default:   t_raw = '0;
        endcase
    end

    // Abort suppresses the toggle in its own cycle; a zero-count pulse never toggles.
    always_comb begin
        t_vec = '0;
        if (state_q == EXEC && !cmd.abort && !(op_q == OP_PULSE && cnt_q == '0)) begin
            t_vec = t_raw;
        end
    end

    always_comb begin
        state_d   = state_q;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: if (cmd.cmd_valid && ready_q) state_d = EXEC;
            EXEC: begin
                if (cmd.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (op_q != OP_PULSE || cnt_q <= CNTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_TOGGLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            aborted_q <= aborted_d;
            if (state_q == IDLE && state_d == EXEC) begin
                op_q   <= cmd.cmd_op;
                mask_q <= cmd.cmd_mask;
                cnt_q  <= cmd.cmd_count;
            end else if (state_q == EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - CNTW'(1);
            end
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;

    assign rst_n = ~rst;

    for (genvar i = 0; i < W; i++) begin : g_bit
        t_ff u_t_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end
endmodule

// File: tb/tb_t_ff_bank_ctrl.sv
// Bench for t_ff_bank_ctrl: directed vector table, reset corner cases, randomized commands vs model.
module tb_t_ff_bank_ctrl;
    import t_ff_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] t_vec;
    logic [7:0] q;
    logic       busy, done, aborted;
    int         n_cmp = 0;
    int         n_bad = 0;

    t_ff_bank_ctrl_if #(.W(8), .CNTW(8)) bus ();

    t_ff_bank_ctrl #(.W(8), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (bus),
        .t_vec   (t_vec),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] m;
        logic [7:0] c;
        int         ab;
        logic [7:0] eq;
        int         ecyc;
        logic       eab;
        logic [7:0] etv;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one command from an IDLE negedge; ab_at = EXEC cycle (1-based) carrying abort, 0 = none.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] m, input logic [7:0] c,
                           input int ab_at, input logic hold,
                           input logic [7:0] exp_q, input int exp_cyc, input logic exp_ab,
                           input logic [7:0] exp_tv1);
        int   n;
        int   w;
        logic rdy_bad;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'd0, bus.cmd_ready}, 1);
        bus.cmd_op    = op_e'(op);
        bus.cmd_mask  = m;
        bus.cmd_count = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.cmd_valid = 1'b0;
        n       = 0;
        rdy_bad = 1'b0;
        while (!done && n < 300) begin
            n++;
            bus.abort = (n == ab_at);
            #1;
            if (n == 1) check("tvec_exec1", {24'd0, t_vec}, {24'd0, exp_tv1});
            if (bus.cmd_ready || !busy) rdy_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.abort = 1'b0;
        end
        check("exec_cycles", n, exp_cyc);
        check("ready_low_busy_high_in_exec", {31'd0, rdy_bad}, 0);
        check("done_q", {24'd0, q}, {24'd0, exp_q});
        check("done_aborted", {31'd0, aborted}, {31'd0, exp_ab});
        check("done_busy", {31'd0, busy}, 1);
        check("done_ready", {31'd0, bus.cmd_ready}, 0);
        check("done_tvec", {24'd0, t_vec}, 0);
        @(negedge clk);
        check("idle_done", {31'd0, done}, 0);
        check("idle_aborted", {31'd0, aborted}, 0);
        check("idle_ready", {31'd0, bus.cmd_ready}, 1);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_q", {24'd0, q}, {24'd0, exp_q});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] qm, qn, m, tv1;
        logic [1:0] op;
        logic [7:0] c;
        int         ex, ab, tog, cyc;

        tbl[0]  = '{2'b00, 8'hA5, 8'd0,  0, 8'hA5, 1, 1'b0, 8'hA5};
        tbl[1]  = '{2'b10, 8'h0F, 8'd0,  0, 8'hAF, 1, 1'b0, 8'h0A};
        tbl[2]  = '{2'b01, 8'hF0, 8'd0,  0, 8'h0F, 1, 1'b0, 8'hA0};
        tbl[3]  = '{2'b01, 8'hFF, 8'd0,  0, 8'h00, 1, 1'b0, 8'h0F};
        tbl[4]  = '{2'b11, 8'h01, 8'd5,  0, 8'h01, 5, 1'b0, 8'h01};
        tbl[5]  = '{2'b00, 8'h01, 8'd0,  0, 8'h00, 1, 1'b0, 8'h01};
        tbl[6]  = '{2'b11, 8'h01, 8'd4,  0, 8'h00, 4, 1'b0, 8'h01};
        tbl[7]  = '{2'b11, 8'h01, 8'd0,  0, 8'h00, 1, 1'b0, 8'h00};
        tbl[8]  = '{2'b11, 8'hFF, 8'd10, 3, 8'h00, 3, 1'b1, 8'hFF};
        tbl[9]  = '{2'b00, 8'h00, 8'd0,  0, 8'h00, 1, 1'b0, 8'h00};
        tbl[10] = '{2'b00, 8'h3C, 8'd0,  1, 8'h00, 1, 1'b1, 8'h00};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_TOGGLE;
        bus.cmd_mask  = '0;
        bus.cmd_count = '0;
        bus.abort     = 1'b0;
        #1;
        check("rst_q", {24'd0, q}, 0);
        check("rst_tvec", {24'd0, t_vec}, 0);
        check("rst_ready", {31'd0, bus.cmd_ready}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_aborted", {31'd0, aborted}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", {31'd0, bus.cmd_ready}, 0);
        @(negedge clk);
        check("ready_after_first_edge", {31'd0, bus.cmd_ready}, 1);

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].op, tbl[i].m, tbl[i].c, tbl[i].ab, 1'b0,
                    tbl[i].eq, tbl[i].ecyc, tbl[i].eab, tbl[i].etv);
        end

        // Asynchronous reset between edges in the middle of a long pulse.
        bus.cmd_op    = OP_PULSE;
        bus.cmd_mask  = 8'hFF;
        bus.cmd_count = 8'd20;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_q", {24'd0, q}, 8'hFF);
        rst = 1'b1;
        #1;
        check("async_rst_q", {24'd0, q}, 0);
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_done", {31'd0, done}, 0);
        check("async_rst_tvec", {24'd0, t_vec}, 0);
        check("async_rst_ready", {31'd0, bus.cmd_ready}, 0);
        @(negedge clk);
        check("rst_hold_done", {31'd0, done}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready_low", {31'd0, bus.cmd_ready}, 0);
        @(negedge clk);
        check("post_rst_ready_high", {31'd0, bus.cmd_ready}, 1);
        check("post_rst_done", {31'd0, done}, 0);
        run_cmd(2'b00, 8'h81, 8'd0, 0, 1'b0, 8'h81, 1, 1'b0, 8'h81);

        // Random commands with cmd_valid held high the whole time.
        qm = 8'h81;
        for (int k = 0; k < 50; k++) begin
            op  = 2'($urandom_range(0, 3));
            m   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            c   = 8'($urandom_range(0, 6));
            ex  = (op == 2'b11) ? ((c == 0) ? 1 : int'(c)) : 1;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ex)) : 0;
            cyc = (ab != 0) ? ab : ex;
            tog = (op == 2'b11 && c == 0) ? 0 : ((ab != 0) ? ab - 1 : ex);
            case (op)
                2'b00:   begin qn = (tog > 0) ? (qm ^ m)  : qm; tv1 = m; end
                2'b01:   begin qn = (tog > 0) ? (qm & ~m) : qm; tv1 = qm & m; end
                2'b10:   begin qn = (tog > 0) ? (qm | m)  : qm; tv1 = ~qm & m; end
                default: begin qn = (tog % 2 == 1) ? (qm ^ m) : qm; tv1 = m; end
            endcase
            if (ab == 1 || (op == 2'b11 && c == 0)) tv1 = 8'h00;
            run_cmd(op, m, c, ab, 1'b1, qn, cyc, (ab != 0), tv1);
            qm = qn;
        end
        bus.cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
